multicycle_ripple_adder: RTL

Parametrised sequential successor to the 2-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, LSB chunk first.
- The carry passes between chunks through a register.
- Valid/ready handshakes on input and output; sum, carry-out and signed overflow are registered.
- Used in the datapath labs where a narrow adder is time-shared across a wide operand.

---
 rtl/multicycle_ripple_adder_pkg.sv | 16 +
 rtl/full_adder.sv | 13 +
 rtl/multicycle_ripple_adder_chunk.sv | 32 +++
 rtl/multicycle_ripple_adder.sv | 130 +++++++++++++
 4 files changed

// File: rtl/multicycle_ripple_adder_pkg.sv
// Shared definitions for the multicycle ripple adder: FSM state encoding and
// the operand-width / chunk-width legality rule.
package multicycle_ripple_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The operand must split into a whole number of non-empty chunks.
    function automatic bit chunk_cfg_legal(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of the chunk adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/multicycle_ripple_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full_adder cells.
// Besides the sum and carry-out it exposes the carry into the chunk MSB so
// the caller can form two's-complement overflow on the final chunk.
module ripple_chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cin_msb
);

    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout    = carry[CHUNK];
    assign cin_msb = carry[CHUNK-1];

endmodule

// File: rtl/multicycle_ripple_adder.sv
// Sequential adder/subtractor: a CHUNK-bit ripple adder is time-shared across
// a WIDTH-bit operand, LSB chunk first, with the carry held in a register
// between chunks. Valid/ready handshakes on both sides; results registered.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | adding one chunk per clock
// DONE  | result presented, out_valid=1, waiting for out_ready
module multicycle_ripple_adder
    import multicycle_ripple_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_A,
    input  logic [WIDTH-1:0] input_B,
    input  logic             input_C0,
    input  logic             input_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] output_S,
    output logic             output_C,
    output logic             output_V
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    if (!chunk_cfg_legal(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("multicycle_ripple_adder: WIDTH must be a multiple of CHUNK and CHUNK >= 1");
    end

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_cin_msb;

    logic accept;
    logic last_chunk;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (state == RUN) && (cnt == LAST_CHUNK);

    ripple_chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a       (a_reg[CHUNK-1:0]),
        .b       (b_reg[CHUNK-1:0]),
        .cin     (carry),
        .sum     (chunk_sum),
        .cout    (chunk_cout),
        .cin_msb (chunk_cin_msb)
    );

    // Chunk sums enter at the top so that after NCHUNK shifts the first
    // (least significant) chunk has arrived at bit 0.
    if (CHUNK == WIDTH) begin : g_psum_full
        assign psum_next = chunk_sum;
    end else begin : g_psum_shift
        assign psum_next = {chunk_sum, psum[WIDTH-1:CHUNK]};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept -> RUN for NCHUNK edges -> DONE until drained.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)     state_next = RUN;
            RUN:     if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, chunk-by-chunk shifting and result registration.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            psum     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            output_S <= '0;
            output_C <= 1'b0;
            output_V <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1; the +1 rides in as the initial carry.
            a_reg <= input_A;
            b_reg <= input_sub ? ~input_B : input_B;
            carry <= input_sub ? 1'b1 : input_C0;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg <= a_reg >> CHUNK;
            b_reg <= b_reg >> CHUNK;
            carry <= chunk_cout;
            psum  <= psum_next;
            cnt   <= cnt + 1'b1;
            if (last_chunk) begin
                output_S <= psum_next;
                output_C <= chunk_cout;
                output_V <= chunk_cout ^ chunk_cin_msb;
            end
        end
    end

endmodule
